gpio_apb_ctrl: RTL and testbench
================================

Name: gpio_apb_ctrl

Overview:
Parametrised APB3 GPIO peripheral, the successor of the fixed 16-bit LED/switch/7-seg GPIO block.
- Configurable output, input and seven-segment digit counts.
- Input synchronisation and rising-edge interrupts, with enable and write-1-to-clear status.
- Per-digit seven-segment blanking, full register readback, and PSLVERR on unmapped offsets.
- Sits on the SoC APB fabric; the fabric decodes the base address.

Parameters:
- OUT_W, 16, width of gpio_out (1..32).
- IN_W, 16, width of gpio_in (1..32).
- SEG_NUM, 8, number of 7-seg digits (1..8).
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_paddr  in  32  APB address; only [4:2] decoded
- in_psel  in  1  APB select
- in_penable  in  1  APB enable (access phase)
- in_pprot  in  3  ignored
- in_pwrite  in  1  1=write
- in_pwdata  in  32  write data
- in_pstrb  in  4  byte strobes
- in_pready  out  1  transfer complete
- in_prdata  out  32  read data, valid when in_pready
- in_pslverr  out  1  error, valid when in_pready
- gpio_out  out  OUT_W  LED outputs
- gpio_in  in  IN_W  asynchronous switch inputs
- gpio_seg  out  8*SEG_NUM  digit i on [8i+7:8i], active-low segments
- irq  out  1  level interrupt

Behaviour:
Reset behaviour:
- clock is the system clock; reset is synchronous, active-high.
- Reset values: gpio_out=0, gpio_seg all 8'hFF, irq=0, in_pready=0, in_prdata=0, in_pslverr=0.
- All registers and synchroniser flops reset to 0.

Register map (offset = paddr[4:2]*4). All registers are zero-extended on read; bits above the parameter width are read 0 and written-ignored.
- 0x00 OUT, RW [OUT_W-1:0].
- 0x04 IN, RO, synchronised input value; writes are accepted with no effect and no error.
- 0x08 SEG, RW [4*SEG_NUM-1:0], one hex nibble per digit; nibble i drives digit i.
- 0x0C SEG_EN, RW [SEG_NUM-1:0]; a digit whose bit is 0 outputs 8'hFF (blank).
- 0x10 IRQ_EN, RW [IN_W-1:0].
- 0x14 IRQ_STAT, W1C [IN_W-1:0].
- 0x18, 0x1C: in_pslverr=1, in_prdata=0, no side effects.

APB FSM (states IDLE and RESP):
- IDLE -> RESP when in_psel & in_penable. In that same cycle, capture the response and commit any write on the clock edge.
- RESP: in_pready=1 for exactly one cycle, then unconditionally to IDLE. Every transfer therefore has exactly one wait state.
- in_prdata and in_pslverr are registered and valid only while in_pready=1; otherwise they are 0.
- A read returns the register value before any same-cycle hardware update.
- Write byte lane b is updated only if in_pstrb[b]=1. This applies to OUT, SEG, SEG_EN and IRQ_EN.
- IRQ_STAT: a 1 in a strobed lane clears that bit.
- in_psel dropped before in_penable: no transfer.
- Reset in RESP: return to IDLE; in_pready=0 the next cycle.

Input path:
- gpio_in passes through SYNC_STAGES flops to form the IN value, plus one delay flop for edge detection.
- rise[i] = sync[i] & ~prev[i].
- A bit toggling at gpio_in appears in IN after SYNC_STAGES clocks; IRQ_STAT[i] sets on the next edge.
- Rising-edge set has priority over a same-cycle W1C of the same bit.
- Edges are recorded regardless of IRQ_EN.
- irq = |(IRQ_STAT & IRQ_EN), combinational from registers.

Seven-segment output:
- Segment bit order is bit7=a … bit1=g, bit0=dp.
- Output is the bitwise NOT of the active-high pattern. Active-high patterns: 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E.
- gpio_seg and gpio_out are registered and change the cycle after the write commits.

Decomposition:
- gpio_apb_pkg holds:
  - register offset constants;
  - the FSM state enum (IDLE, RESP);
  - a function hex_to_seg(4-bit) returning the active-low 8-bit code.
- One sub-module, gpio_in_sync (params IN_W, SYNC_STAGES; outputs sync value and rise vector), instantiated once.
- Everything else stays in gpio_apb_ctrl.

Test Plan:
1. Reset, then read every offset -> in_prdata 0 and gpio_seg all FF; 0x18 read -> pslverr=1, prdata=0.
2. Write OUT=0x0000A5C3 strb=4'b0001 -> gpio_out=0x00C3; read back 0x000000C3; in_pready high exactly one cycle after the access-phase cycle.
3. Write SEG=0x76543210 strb=F, then SEG_EN=0x05 -> digit0=03, digit2=25 (~DA), other digits FF; then SEG_EN=0xFF -> digit1=9F, digit7=1F (~E0).
4. gpio_in 0->0x0001 -> IN reads 1 after SYNC_STAGES clocks; IRQ_STAT[0]=1; irq=0 until IRQ_EN=1, then irq=1.
5. W1C of IRQ_STAT=0x1 in the same cycle as a new rise on bit0 -> bit stays 1; a later W1C with no edge -> 0 and irq=0.
6. Assert reset while in RESP -> in_pready=0 next cycle, gpio_out=0, IRQ_STAT=0.

Source files
------------

// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the APB GPIO peripheral: register map, APB FSM states, 7-seg decode.
package gpio_apb_pkg;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned IDX_W  = 3;

  // Word indices decoded from paddr[4:2]; the byte offset is the index times four.
  localparam logic [IDX_W-1:0] REG_OUT      = 3'd0;
  localparam logic [IDX_W-1:0] REG_IN       = 3'd1;
  localparam logic [IDX_W-1:0] REG_SEG      = 3'd2;
  localparam logic [IDX_W-1:0] REG_SEG_EN   = 3'd3;
  localparam logic [IDX_W-1:0] REG_IRQ_EN   = 3'd4;
  localparam logic [IDX_W-1:0] REG_IRQ_STAT = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } apb_state_t;

  // Hex nibble to active-low segment code, bit7=a .. bit1=g, bit0=dp.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] pat;
    case (hex)
      4'h0:    pat = 8'hFC;
      4'h1:    pat = 8'h60;
      4'h2:    pat = 8'hDA;
      4'h3:    pat = 8'hF2;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'hB6;
      4'h6:    pat = 8'hBE;
      4'h7:    pat = 8'hE0;
      4'h8:    pat = 8'hFE;
      4'h9:    pat = 8'hF6;
      4'hA:    pat = 8'hEE;
      4'hB:    pat = 8'h3E;
      4'hC:    pat = 8'h9C;
      4'hD:    pat = 8'h7A;
      4'hE:    pat = 8'h9E;
      default: pat = 8'h8E;
    endcase
    return ~pat;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-flop synchroniser for asynchronous switch inputs plus rising-edge detection.
module gpio_in_sync #(
  parameter int unsigned IN_W        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] pins,
  output logic [IN_W-1:0] value,
  output logic [IN_W-1:0] rise
);

  logic [IN_W-1:0] stage [SYNC_STAGES];
  logic [IN_W-1:0] prev;

  // Shift the raw inputs through the synchroniser chain and keep one delayed copy for edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= pins;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign value = stage[SYNC_STAGES-1];
  assign rise  = value & ~prev;

endmodule

// File: rtl/gpio_apb_ctrl.sv
// APB3 GPIO peripheral: LED outputs, synchronised switch inputs with edge IRQs, 7-seg digits.
module gpio_apb_ctrl
  import gpio_apb_pkg::*;
#(
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned SEG_NUM     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          in_paddr,
  input  logic                 in_psel,
  input  logic                 in_penable,
  input  logic [2:0]           in_pprot,
  input  logic                 in_pwrite,
  input  logic [31:0]          in_pwdata,
  input  logic [3:0]           in_pstrb,
  output logic                 in_pready,
  output logic [31:0]          in_prdata,
  output logic                 in_pslverr,
  output logic [OUT_W-1:0]     gpio_out,
  input  logic [IN_W-1:0]      gpio_in,
  output logic [8*SEG_NUM-1:0] gpio_seg,
  output logic                 irq
);

  localparam int unsigned SEG_W = 4 * SEG_NUM;

  apb_state_t          state;
  logic [OUT_W-1:0]    out_reg,  out_nxt;
  logic [SEG_W-1:0]    seg_reg,  seg_nxt;
  logic [SEG_NUM-1:0]  seg_en,   seg_en_nxt;
  logic [IN_W-1:0]     irq_en,   irq_en_nxt;
  logic [IN_W-1:0]     irq_stat, irq_stat_nxt;
  logic [IN_W-1:0]     in_sync,  in_rise;
  logic                access_c, wr_c, err_c;
  logic [IDX_W-1:0]    idx_c;
  logic [APB_DW-1:0]   lane_mask_c, rdata_c;
  logic                unused_ok;

  gpio_in_sync #(
    .IN_W        (IN_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clock (clock),
    .reset (reset),
    .pins  (gpio_in),
    .value (in_sync),
    .rise  (in_rise)
  );

  assign access_c = (state == IDLE) && in_psel && in_penable;
  assign wr_c     = access_c && in_pwrite;
  assign idx_c    = in_paddr[4:2];

  // Expand byte strobes into a per-bit write mask.
  always_comb begin
    lane_mask_c = '0;
    for (int unsigned b = 0; b < 4; b++) lane_mask_c[8*b +: 8] = {8{in_pstrb[b]}};
  end

  // Read mux over the pre-update register values; unmapped offsets flag an error.
  always_comb begin
    rdata_c = '0;
    err_c   = 1'b0;
    case (idx_c)
      REG_OUT:      rdata_c = 32'(out_reg);
      REG_IN:       rdata_c = 32'(in_sync);
      REG_SEG:      rdata_c = 32'(seg_reg);
      REG_SEG_EN:   rdata_c = 32'(seg_en);
      REG_IRQ_EN:   rdata_c = 32'(irq_en);
      REG_IRQ_STAT: rdata_c = 32'(irq_stat);
      default:      err_c   = 1'b1;
    endcase
  end

  // Strobed register writes; edge capture is applied after W1C so a new edge wins.
  always_comb begin
    out_nxt      = out_reg;
    seg_nxt      = seg_reg;
    seg_en_nxt   = seg_en;
    irq_en_nxt   = irq_en;
    irq_stat_nxt = irq_stat;
    if (wr_c) begin
      case (idx_c)
        REG_OUT:      out_nxt    = (out_reg & ~lane_mask_c[OUT_W-1:0])
                                 | (in_pwdata[OUT_W-1:0] & lane_mask_c[OUT_W-1:0]);
        REG_SEG:      seg_nxt    = (seg_reg & ~lane_mask_c[SEG_W-1:0])
                                 | (in_pwdata[SEG_W-1:0] & lane_mask_c[SEG_W-1:0]);
        REG_SEG_EN:   seg_en_nxt = (seg_en & ~lane_mask_c[SEG_NUM-1:0])
                                 | (in_pwdata[SEG_NUM-1:0] & lane_mask_c[SEG_NUM-1:0]);
        REG_IRQ_EN:   irq_en_nxt = (irq_en & ~lane_mask_c[IN_W-1:0])
                                 | (in_pwdata[IN_W-1:0] & lane_mask_c[IN_W-1:0]);
        REG_IRQ_STAT: irq_stat_nxt = irq_stat & ~(in_pwdata[IN_W-1:0] & lane_mask_c[IN_W-1:0]);
        default:      ;
      endcase
    end
    irq_stat_nxt = irq_stat_nxt | in_rise;
  end

  // Register bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_reg  <= '0;
      seg_reg  <= '0;
      seg_en   <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
    end else begin
      out_reg  <= out_nxt;
      seg_reg  <= seg_nxt;
      seg_en   <= seg_en_nxt;
      irq_en   <= irq_en_nxt;
      irq_stat <= irq_stat_nxt;
    end
  end

  // Output stage: LED pins and decoded, per-digit blanked segment codes.
  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_seg <= '1;
    end else begin
      gpio_out <= out_reg;
      for (int unsigned i = 0; i < SEG_NUM; i++) begin
        gpio_seg[8*i +: 8] <= seg_en[i] ? hex_to_seg(seg_reg[4*i +: 4]) : 8'hFF;
      end
    end
  end

  // APB slave FSM: one wait state, response registered and held for a single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_pready  <= 1'b0;
      in_prdata  <= '0;
      in_pslverr <= 1'b0;
    end else begin
      in_pready  <= 1'b0;
      in_prdata  <= '0;
      in_pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (access_c) begin
            state      <= RESP;
            in_pready  <= 1'b1;
            in_prdata  <= rdata_c;
            in_pslverr <= err_c;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = |(irq_stat & irq_en);

  // Address bits outside [4:2], protection bits and wide write data are not decoded.
  assign unused_ok = ^{in_pprot, in_paddr[31:5], in_paddr[1:0], in_pwdata, lane_mask_c};

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Directed plus randomized bench for gpio_apb_ctrl against a register-level reference model.
module tb_gpio_apb_ctrl;

  localparam int unsigned OUT_W   = 16;
  localparam int unsigned IN_W    = 16;
  localparam int unsigned SEG_NUM = 8;
  localparam int unsigned SYNC    = 2;

  localparam logic [7:0] PAT [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          in_paddr;
  logic                 in_psel, in_penable, in_pwrite;
  logic [2:0]           in_pprot;
  logic [31:0]          in_pwdata;
  logic [3:0]           in_pstrb;
  logic                 in_pready, in_pslverr;
  logic [31:0]          in_prdata;
  logic [OUT_W-1:0]     gpio_out;
  logic [IN_W-1:0]      gpio_in;
  logic [8*SEG_NUM-1:0] gpio_seg;
  logic                 irq;

  int total = 0;
  int bad   = 0;
  int last_waits;

  // Reference model state (full 32-bit words, masked to legal widths)
  logic [31:0] m_out, m_in, m_seg, m_seg_en, m_irq_en, m_stat;

  gpio_apb_ctrl #(.OUT_W(OUT_W), .IN_W(IN_W), .SEG_NUM(SEG_NUM), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel),
    .in_penable(in_penable), .in_pprot(in_pprot), .in_pwrite(in_pwrite),
    .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
    .in_prdata(in_prdata), .in_pslverr(in_pslverr), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .gpio_seg(gpio_seg), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [31:0] wmask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s, input int unsigned w);
    return ((old & ~bmask(s)) | (wd & bmask(s))) & wmask(w);
  endfunction

  function automatic logic [63:0] exp_seg();
    logic [63:0] r;
    logic [3:0]  n;
    r = '1;
    for (int i = 0; i < SEG_NUM; i++) begin
      n = m_seg[4*i +: 4];
      r[8*i +: 8] = m_seg_en[i] ? ~PAT[n] : 8'hFF;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return m_out;
      3'd1:    return m_in;
      3'd2:    return m_seg;
      3'd3:    return m_seg_en;
      3'd4:    return m_irq_en;
      3'd5:    return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_seg = '0; m_seg_en = '0; m_irq_en = '0; m_stat = '0;
  endtask

  // One APB transfer with a bounded wait for in_pready
  task automatic apb_xfer(input logic [2:0] idx, input logic wr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] rd, output logic err);
    logic [31:0] a;
    logic        got;
    a = $urandom();
    a[4:2] = idx;
    @(posedge clock); #1;
    in_paddr = a; in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr;
    in_pwdata = wd; in_pstrb = strb; in_pprot = 3'($urandom());
    @(posedge clock); #1;
    in_penable = 1'b1;
    got = 1'b0; rd = '0; err = 1'b0; last_waits = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clock); #1;
      last_waits++;
      if (in_pready) begin
        got = 1'b1; rd = in_prdata; err = in_pslverr;
      end
    end
    check("pready_seen", 64'(got), 64'd1);
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] rd;
    logic        err;
    apb_xfer(idx, 1'b1, wd, strb, rd, err);
    check("wr_slverr", 64'(err), 64'(idx >= 3'd6));
    case (idx)
      3'd0: m_out    = merge(m_out, wd, strb, OUT_W);
      3'd2: m_seg    = merge(m_seg, wd, strb, 4*SEG_NUM);
      3'd3: m_seg_en = merge(m_seg_en, wd, strb, SEG_NUM);
      3'd4: m_irq_en = merge(m_irq_en, wd, strb, IN_W);
      3'd5: m_stat   = m_stat & ~(wd & bmask(strb)) & wmask(IN_W);
      default: ;
    endcase
  endtask

  task automatic do_read(input logic [2:0] idx);
    logic [31:0] rd;
    logic        err;
    apb_xfer(idx, 1'b0, $urandom(), 4'($urandom()), rd, err);
    check($sformatf("rd_data_%0d", idx), 64'(rd), 64'(exp_read(idx)));
    check($sformatf("rd_slverr_%0d", idx), 64'(err), 64'(idx >= 3'd6));
  endtask

  task automatic check_outputs();
    @(posedge clock); #1;
    check("gpio_out", 64'(gpio_out), 64'(m_out));
    check("gpio_seg", gpio_seg, exp_seg());
    check("irq", 64'(irq), 64'(|(m_stat & m_irq_en)));
  endtask

  // Drive new switch levels and let them settle through synchroniser and edge capture
  task automatic set_in(input logic [31:0] v);
    logic [31:0] nv;
    nv = v & wmask(IN_W);
    @(posedge clock); #1;
    gpio_in = nv[IN_W-1:0];
    repeat (SYNC + 2) @(posedge clock);
    #1;
    m_stat = m_stat | (nv & ~m_in);
    m_in   = nv;
  endtask

  initial begin
    reset = 1'b1; in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    in_pwdata = '0; in_pstrb = '0; in_pprot = '0; gpio_in = '0;
    model_reset();
    m_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_gpio_out", 64'(gpio_out), 64'd0);
    check("rst_gpio_seg", gpio_seg, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_pready", 64'(in_pready), 64'd0);
    check("rst_prdata", 64'(in_prdata), 64'd0);
    check("rst_pslverr", 64'(in_pslverr), 64'd0);
    reset = 1'b0;

    // 1: every offset reads zero after reset, 0x18/0x1C error
    for (int i = 0; i < 8; i++) do_read(3'(i));

    // 2: byte-strobed OUT write, one wait state, single-cycle pready
    do_write(3'd0, 32'h0000_A5C3, 4'b0001);
    check("wait_states", 64'(last_waits), 64'd1);
    @(posedge clock); #1;
    check("pready_drop", 64'(in_pready), 64'd0);
    check("gpio_out_c3", 64'(gpio_out), 64'h00C3);
    do_read(3'd0);

    // 3: seven-segment decode and blanking
    do_write(3'd2, 32'h7654_3210, 4'hF);
    do_write(3'd3, 32'h0000_0005, 4'hF);
    check_outputs();
    check("digit0", 64'(gpio_seg[7:0]), 64'h03);
    check("digit2", 64'(gpio_seg[23:16]), 64'h25);
    check("digit1_blank", 64'(gpio_seg[15:8]), 64'hFF);
    do_write(3'd3, 32'h0000_00FF, 4'hF);
    check_outputs();
    check("digit1", 64'(gpio_seg[15:8]), 64'h9F);
    check("digit7", 64'(gpio_seg[63:56]), 64'h1F);

    // 4: input sync, edge capture independent of enable
    set_in(32'h0001);
    do_read(3'd1);
    do_read(3'd5);
    check("irq_masked", 64'(irq), 64'd0);
    do_write(3'd4, 32'h0000_0001, 4'hF);
    check("irq_enabled", 64'(irq), 64'd1);

    // 5: edge in the same cycle as W1C of that bit keeps it set
    set_in(32'h0000);
    do_write(3'd5, 32'h0000_0001, 4'hF);
    check("stat_cleared", 64'(irq), 64'd0);
    @(posedge clock); #1;
    gpio_in = 16'h0001;
    repeat (SYNC - 1) @(posedge clock);
    #1;
    in_paddr = 32'h0000_0014; in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b1;
    in_pwdata = 32'h0000_0001; in_pstrb = 4'hF;
    @(posedge clock); #1;
    in_penable = 1'b1;
    @(posedge clock); #1;
    check("race_pready", 64'(in_pready), 64'd1);
    in_psel = 1'b0; in_penable = 1'b0;
    m_in = 32'h1; m_stat = 32'h1;
    do_read(3'd5);
    do_write(3'd5, 32'h0000_0001, 4'b0001);
    do_read(3'd5);
    check("irq_after_w1c", 64'(irq), 64'd0);

    // Edge latency: status must not set before SYNC clocks, and must set on the next one
    set_in(32'h0000);
    @(posedge clock); #1;
    gpio_in = 16'h0001;
    repeat (SYNC) @(posedge clock);
    #1;
    check("irq_too_early", 64'(irq), 64'd0);
    @(posedge clock); #1;
    check("irq_on_time", 64'(irq), 64'd1);
    m_in = 32'h1; m_stat = m_stat | 32'h1;

    // Randomized register and input traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: do_write(3'($urandom_range(0, 7)), $urandom(), 4'($urandom()));
        2:    do_read(3'($urandom_range(0, 7)));
        default: set_in($urandom());
      endcase
      check_outputs();
    end
    for (int i = 0; i < 8; i++) do_read(3'(i));

    // 6: reset while the response is being presented
    set_in(32'h0000);
    do_write(3'd4, 32'h0000_FFFF, 4'hF);
    @(posedge clock); #1;
    in_paddr = 32'h0; in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b1;
    in_pwdata = 32'h0000_FFFF; in_pstrb = 4'hF;
    @(posedge clock); #1;
    in_penable = 1'b1;
    @(posedge clock); #1;
    check("resp_pready", 64'(in_pready), 64'd1);
    reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
    @(posedge clock); #1;
    check("rst_resp_pready", 64'(in_pready), 64'd0);
    check("rst_resp_out", 64'(gpio_out), 64'd0);
    reset = 1'b0;
    model_reset();
    do_read(3'd5);
    do_read(3'd0);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
